motor_ramp_ctrl: RTL and testbench
==================================

Name: motor_ramp_ctrl

Overview:
- Sequences the duty-cycle value fed to the PWM generator of one DC motor channel.
- Ramps duty toward a register-programmed target in fixed steps, aligned to PWM period boundaries.
- On a direction request it decelerates to zero and holds a dead time before flipping the H-bridge direction.
- Sits between the AXI register block (target/config) and the PWM generator plus the H-bridge DIR pin.

Parameters:
- DUTY_WIDTH, 15, width of duty values; must match the PWM generator.
- STEP_WIDTH, 8, width of the ramp step size.
- DIV_WIDTH, 16, width of the ramp divider and the dead-time counter.

Ports:
- clk  in  1  system/PWM clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  channel enable; low = immediate stop.
- tgt_duty  in  DUTY_WIDTH  requested duty.
- tgt_dir  in  1  requested direction.
- step  in  STEP_WIDTH  duty increment per ramp tick.
- ramp_div  in  DIV_WIDTH  PWM periods per ramp tick; 0 is treated as 1.
- dead_cycles  in  DIV_WIDTH  dead-time length in clk cycles.
- period_start  in  1  one-cycle pulse when the PWM counter wraps to 0.
- duty  out  DUTY_WIDTH  duty to the PWM generator.
- dir  out  1  H-bridge direction.
- busy  out  1  enabled and not at target.
- at_target  out  1  duty==tgt_duty and dir==tgt_dir in RAMP.

Behaviour:
- Reset/clock: reset is synchronous, active-high; clock is clk.
- Reset values: state=IDLE, duty=0, dir=0, busy=0, at_target=0, prescaler=0, dead counter=0.
- States: IDLE, DEAD, RAMP. All outputs are registered.
- IDLE:
  - duty held at 0.
  - enable=1 -> DEAD, dead counter loaded with dead_cycles.
- enable=0 in any state: next cycle duty=0, state=IDLE, dir unchanged. This is an emergency stop with no ramp.
- DEAD:
  - duty=0; counter decrements each clk.
  - When counter==0: dir<=tgt_dir, state<=RAMP, prescaler cleared.
  - Total time in DEAD is dead_cycles+1 clk cycles.
- Ramp tick:
  - Prescaler counts period_start pulses in RAMP.
  - Tick fires on the pulse that makes the count equal max(ramp_div,1); the count then restarts at 0.
  - Duty changes only on a tick, i.e. in the cycle of a period_start pulse, so the update is aligned to the PWM period.
- RAMP, tgt_dir==dir, on tick:
  - Target selection: tgt_duty and tgt_dir are sampled live at each tick; there is no latch, so a mid-ramp target change retargets on the next tick.
  - Compute d = tgt_duty - duty in DUTY_WIDTH+1 signed arithmetic.
  - |d| <= step: duty=tgt_duty. Never overshoots.
  - d > step: duty += step.
  - d < -step: duty -= step.
  - step=0: duty frozen.
- RAMP, tgt_dir!=dir:
  - On each tick, duty moves toward 0 by step, saturating at 0.
  - duty==0 -> DEAD, counter reloaded. This check is evaluated every cycle, not only on ticks.
- DEAD exit: dir<=tgt_dir sampled at exit. If the request reverted during DEAD, dir is unchanged and RAMP resumes.
- at_target = (state==RAMP) && duty==tgt_duty && dir==tgt_dir, registered, one cycle after the condition holds.
- busy = (state!=IDLE) && !at_target.
- dir changes only on the DEAD->RAMP transition, with duty==0, so it never toggles while duty is nonzero.

Decomposition:
- Package motor_ctrl_pkg:
  - state enum (IDLE=2'd0, DEAD=2'd1, RAMP=2'd2).
  - DUTY_WIDTH default constant.
  - saturating-step function.
- One sub-module, ramp_prescaler: the period_start counter with clear input and ramp_div compare. It emits the tick pulse.

Test Plan:
- Reset, enable=1, dead_cycles=3, tgt_duty=100, step=30, ramp_div=1 -> 4 DEAD cycles, then on successive period_start duty=30,60,90,100; at_target=1 after 100; busy=0.
- From duty=100 dir=0, set tgt_dir=1, step=40 -> ticks give duty 60,20,0; DEAD for dead_cycles+1 cycles; dir=1; ramp up to 100. dir never changes while duty!=0.
- ramp_div=0 vs ramp_div=3, step=10, target 50 -> duty changes on every period_start vs every 3rd; no change between pulses.
- Mid-ramp at duty=60 (ramp from 0 toward 100), drop tgt_duty to 40, step=30 -> next tick duty=40 (no undershoot), at_target=1.
- enable=0 at duty=500 -> next cycle duty=0, state IDLE; re-enable -> DEAD then ramp from 0.
- reset asserted during DEAD and during RAMP -> next cycle all outputs at reset values; step=0 with tgt=10 -> duty stays 0, busy=1.

Source files
------------

// File: rtl/motor_ctrl_pkg.sv
// Shared types and helpers for the motor ramp controller.
// Holds the FSM state encoding, default widths and the step-toward-target arithmetic.
package motor_ctrl_pkg;

  localparam int unsigned DEF_DUTY_WIDTH = 15;
  localparam int unsigned DEF_STEP_WIDTH = 8;
  localparam int unsigned DEF_DIV_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    RAMP = 2'd2
  } ctrl_state_e;

  // Move cur toward tgt by at most stp; lands exactly on tgt when within one step.
  function automatic logic [31:0] sat_step(input logic [31:0] cur,
                                           input logic [31:0] tgt,
                                           input logic [31:0] stp);
    logic [31:0] res;
    if (cur < tgt) begin
      res = ((tgt - cur) <= stp) ? tgt : (cur + stp);
    end else begin
      res = ((cur - tgt) <= stp) ? tgt : (cur - stp);
    end
    return res;
  endfunction

endpackage

// File: rtl/motor_ramp_ctrl_prescaler.sv
// Counts PWM period_start pulses and emits a one-cycle ramp tick every max(ramp_div,1) pulses.
// The tick is combinational so it coincides with the period_start pulse that produces it.
module ramp_prescaler #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 period_start,
  input  logic [DIV_WIDTH-1:0] ramp_div,
  output logic                 tick_c
);

  logic [DIV_WIDTH-1:0] count;
  logic [DIV_WIDTH:0]   count_inc;
  logic [DIV_WIDTH:0]   div_eff;

  // A divider of zero behaves as one: every pulse is a tick.
  always_comb begin
    count_inc = {1'b0, count} + (DIV_WIDTH+1)'(1);
    div_eff   = (ramp_div == '0) ? (DIV_WIDTH+1)'(1) : {1'b0, ramp_div};
    tick_c    = !clear && period_start && (count_inc == div_eff);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (period_start) begin
      count <= tick_c ? '0 : count_inc[DIV_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Duty-cycle sequencer for one DC motor channel: ramps toward the programmed target on
// PWM-aligned ticks and brakes to zero with a dead time before reversing the H-bridge.
module motor_ramp_ctrl
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned DUTY_WIDTH = DEF_DUTY_WIDTH,
  parameter int unsigned STEP_WIDTH = DEF_STEP_WIDTH,
  parameter int unsigned DIV_WIDTH  = DEF_DIV_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DUTY_WIDTH-1:0] tgt_duty,
  input  logic                  tgt_dir,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [DIV_WIDTH-1:0]  ramp_div,
  input  logic [DIV_WIDTH-1:0]  dead_cycles,
  input  logic                  period_start,
  output logic [DUTY_WIDTH-1:0] duty,
  output logic                  dir,
  output logic                  busy,
  output logic                  at_target
);

  ctrl_state_e          state;
  logic [DIV_WIDTH-1:0] dead_cnt;
  logic                 tick_c;
  logic                 presc_clear_c;
  logic                 at_target_c;
  logic [DUTY_WIDTH-1:0] ramp_duty_c;
  logic [DUTY_WIDTH-1:0] brake_duty_c;

  // Prescaler only runs in RAMP, so it always starts from zero after a dead time.
  assign presc_clear_c = (state != RAMP);

  ramp_prescaler #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_prescaler (
    .clk          (clk),
    .reset        (reset),
    .clear        (presc_clear_c),
    .period_start (period_start),
    .ramp_div     (ramp_div),
    .tick_c       (tick_c)
  );

  // Candidate duties for a tick; target is sampled live, braking saturates at zero.
  always_comb begin
    ramp_duty_c  = DUTY_WIDTH'(sat_step(32'(duty), 32'(tgt_duty), 32'(step)));
    brake_duty_c = DUTY_WIDTH'(sat_step(32'(duty), 32'd0, 32'(step)));
    at_target_c  = enable && (state == RAMP) && (duty == tgt_duty) && (dir == tgt_dir);
  end

  // Sequencer: dir only ever changes on DEAD exit, where duty is already zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      duty      <= '0;
      dir       <= 1'b0;
      busy      <= 1'b0;
      at_target <= 1'b0;
      dead_cnt  <= '0;
    end else begin
      at_target <= at_target_c;
      busy      <= enable && !at_target_c;
      if (!enable) begin
        state <= IDLE;
        duty  <= '0;
      end else begin
        case (state)
          IDLE: begin
            duty     <= '0;
            state    <= DEAD;
            dead_cnt <= dead_cycles;
          end
          DEAD: begin
            duty <= '0;
            if (dead_cnt == '0) begin
              dir   <= tgt_dir;
              state <= RAMP;
            end else begin
              dead_cnt <= dead_cnt - DIV_WIDTH'(1);
            end
          end
          RAMP: begin
            if (tgt_dir != dir) begin
              if (duty == '0) begin
                state    <= DEAD;
                dead_cnt <= dead_cycles;
              end else if (tick_c) begin
                duty <= brake_duty_c;
              end
            end else if (tick_c) begin
              duty <= ramp_duty_c;
            end
          end
          default: begin
            state <= IDLE;
            duty  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Self-checking bench for motor_ramp_ctrl: directed vector table, corner sequences,
// and randomized traffic against a cycle-level behavioural model.
module tb_motor_ramp_ctrl;

  localparam int DW = 15;
  localparam int SW = 8;
  localparam int VW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [DW-1:0] tgt_duty;
  logic          tgt_dir;
  logic [SW-1:0] step;
  logic [VW-1:0] ramp_div;
  logic [VW-1:0] dead_cycles;
  logic          period_start;
  logic [DW-1:0] duty;
  logic          dir;
  logic          busy;
  logic          at_target;

  always #5 clk = ~clk;

  motor_ramp_ctrl #(
    .DUTY_WIDTH (DW),
    .STEP_WIDTH (SW),
    .DIV_WIDTH  (VW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .tgt_duty     (tgt_duty),
    .tgt_dir      (tgt_dir),
    .step         (step),
    .ramp_div     (ramp_div),
    .dead_cycles  (dead_cycles),
    .period_start (period_start),
    .duty         (duty),
    .dir          (dir),
    .busy         (busy),
    .at_target    (at_target)
  );

  int n_pass   = 0;
  int n_checks = 0;
  int cycle_no = 0;
  logic prev_dir = 1'b0;

  // Behavioural model state: 0 = idle, 1 = dead time, 2 = ramping
  int m_st, m_duty, m_dir, m_dead, m_pre, m_at, m_busy;

  typedef struct {
    logic en;
    logic ps;
    int   duty;
    int   busy;
    int   at;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d, want %0d", name, cycle_no, act, exp);
  endtask

  // Next-cycle outputs computed straight from the rules of the controller.
  task automatic model_step();
    int  n_at, lim, d, s, t;
    bit  tick;
    s = int'(step);
    t = int'(tgt_duty);
    if (reset) begin
      m_st = 0; m_duty = 0; m_dir = 0; m_dead = 0; m_pre = 0; m_at = 0; m_busy = 0;
    end else begin
      n_at   = (enable && m_st == 2 && m_duty == t && m_dir == int'(tgt_dir)) ? 1 : 0;
      m_busy = (enable && n_at == 0) ? 1 : 0;
      m_at   = n_at;
      if (!enable) begin
        m_st = 0; m_duty = 0; m_pre = 0;
      end else if (m_st == 0) begin
        m_st = 1; m_dead = int'(dead_cycles);
      end else if (m_st == 1) begin
        if (m_dead == 0) begin
          m_dir = int'(tgt_dir); m_st = 2; m_pre = 0;
        end else begin
          m_dead = m_dead - 1;
        end
      end else begin
        tick = 1'b0;
        lim  = (ramp_div == '0) ? 1 : int'(ramp_div);
        if (period_start) begin
          m_pre = m_pre + 1;
          if (m_pre == lim) begin tick = 1'b1; m_pre = 0; end
        end
        if (int'(tgt_dir) != m_dir) begin
          if (m_duty == 0) begin
            m_st = 1; m_dead = int'(dead_cycles);
          end else if (tick) begin
            m_duty = (m_duty > s) ? m_duty - s : 0;
          end
        end else if (tick) begin
          d = t - m_duty;
          if (d <= s && d >= -s) m_duty = t;
          else if (d > 0)        m_duty = m_duty + s;
          else                   m_duty = m_duty - s;
        end
      end
    end
  endtask

  // One clock: apply period_start, advance model, compare all outputs after the edge.
  task automatic cyc(input logic ps);
    period_start = ps;
    model_step();
    @(posedge clk);
    #1;
    cycle_no++;
    check("model_duty", int'(duty), m_duty);
    check("model_dir", int'(dir), m_dir);
    check("model_busy", int'(busy), m_busy);
    check("model_at_target", int'(at_target), m_at);
    if (dir !== prev_dir) check("dir_flip_duty_zero", int'(duty), 0);
    prev_dir = dir;
  endtask

  task automatic restart(input int dc, input int td, input int st, input int rd, input logic tdir);
    reset = 1'b1; enable = 1'b0;
    cyc(1'b0);
    reset = 1'b0;
    dead_cycles = VW'(dc); tgt_duty = DW'(td); step = SW'(st); ramp_div = VW'(rd);
    tgt_dir = tdir; enable = 1'b1;
    cyc(1'b0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; tgt_duty = '0; tgt_dir = 1'b0; step = '0;
    ramp_div = '0; dead_cycles = '0; period_start = 1'b0;

    tbl[0]  = '{1'b1, 1'b0,   0, 1, 0};
    tbl[1]  = '{1'b1, 1'b0,   0, 1, 0};
    tbl[2]  = '{1'b1, 1'b1,   0, 1, 0};
    tbl[3]  = '{1'b1, 1'b1,   0, 1, 0};
    tbl[4]  = '{1'b1, 1'b1,   0, 1, 0};
    tbl[5]  = '{1'b1, 1'b1,  30, 1, 0};
    tbl[6]  = '{1'b1, 1'b0,  30, 1, 0};
    tbl[7]  = '{1'b1, 1'b1,  60, 1, 0};
    tbl[8]  = '{1'b1, 1'b1,  90, 1, 0};
    tbl[9]  = '{1'b1, 1'b1, 100, 1, 0};
    tbl[10] = '{1'b1, 1'b0, 100, 0, 1};
    tbl[11] = '{1'b1, 1'b1, 100, 0, 1};

    cyc(1'b0);
    cyc(1'b0);
    check("rst_duty", int'(duty), 0);
    check("rst_dir", int'(dir), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_at_target", int'(at_target), 0);
    reset = 1'b0;

    // Basic ramp: 4 dead cycles then 30, 60, 90, 100
    dead_cycles = VW'(3); tgt_duty = DW'(100); step = SW'(30); ramp_div = VW'(1);
    for (int i = 0; i < 12; i++) begin
      enable = tbl[i].en;
      cyc(tbl[i].ps);
      check("tbl_duty", int'(duty), tbl[i].duty);
      check("tbl_busy", int'(busy), tbl[i].busy);
      check("tbl_at_target", int'(at_target), tbl[i].at);
    end

    // Reversal: brake 60, 20, 0, dead time, flip dir, ramp back up
    tgt_dir = 1'b1; step = SW'(40);
    cyc(1'b0);
    cyc(1'b1); check("rev_duty_60", int'(duty), 60);
    cyc(1'b0);
    cyc(1'b1); check("rev_duty_20", int'(duty), 20);
    cyc(1'b1); check("rev_duty_0", int'(duty), 0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1);
      check("rev_dead_dir", int'(dir), 0);
      check("rev_dead_duty", int'(duty), 0);
    end
    cyc(1'b1); check("rev_dir_flipped", int'(dir), 1);
    cyc(1'b1); check("rev_up_40", int'(duty), 40);
    cyc(1'b1); check("rev_up_80", int'(duty), 80);
    cyc(1'b1); check("rev_up_100", int'(duty), 100);

    // Divider 0 ticks every pulse, divider 3 every third pulse
    restart(0, 50, 10, 0, 1'b0);
    cyc(1'b0);
    cyc(1'b1); check("div0_first", int'(duty), 10);
    cyc(1'b0); check("div0_hold", int'(duty), 10);
    cyc(1'b1); check("div0_second", int'(duty), 20);
    ramp_div = VW'(3);
    cyc(1'b1); check("div3_p1", int'(duty), 20);
    cyc(1'b0); check("div3_gap", int'(duty), 20);
    cyc(1'b1); check("div3_p2", int'(duty), 20);
    cyc(1'b1); check("div3_p3", int'(duty), 30);

    // Mid-ramp retarget lands exactly without undershoot
    restart(0, 100, 30, 0, 1'b0);
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b1); check("retgt_60", int'(duty), 60);
    tgt_duty = DW'(40);
    cyc(1'b1); check("retgt_40", int'(duty), 40);
    cyc(1'b0); check("retgt_at", int'(at_target), 1);
    check("retgt_busy", int'(busy), 0);

    // Emergency stop at 500 and re-enable from zero
    restart(0, 500, 255, 0, 1'b0);
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b1); check("estop_pre", int'(duty), 500);
    enable = 1'b0;
    cyc(1'b0); check("estop_duty", int'(duty), 0);
    check("estop_busy", int'(busy), 0);
    enable = 1'b1;
    cyc(1'b1); check("reen_dead1", int'(duty), 0);
    cyc(1'b1); check("reen_dead2", int'(duty), 0);
    cyc(1'b1); check("reen_ramp", int'(duty), 255);

    // Reset while in dead time and while ramping in reverse direction
    restart(5, 50, 10, 0, 1'b0);
    cyc(1'b0);
    reset = 1'b1;
    cyc(1'b0); check("rst_dead_busy", int'(busy), 0);
    check("rst_dead_duty", int'(duty), 0);
    reset = 1'b0;
    restart(0, 200, 50, 0, 1'b1);
    cyc(1'b0); check("rst_ramp_dir_pre", int'(dir), 1);
    cyc(1'b1); check("rst_ramp_duty_pre", int'(duty), 50);
    reset = 1'b1;
    cyc(1'b0);
    check("rst_ramp_duty", int'(duty), 0);
    check("rst_ramp_dir", int'(dir), 0);
    check("rst_ramp_busy", int'(busy), 0);
    check("rst_ramp_at", int'(at_target), 0);
    reset = 1'b0;

    // Zero step freezes duty and stays busy
    restart(0, 10, 0, 0, 1'b0);
    cyc(1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1);
    check("step0_duty", int'(duty), 0);
    check("step0_busy", int'(busy), 1);

    // Randomized traffic against the model
    restart(2, 300, 40, 1, 1'b0);
    for (int c = 0; c < 4000; c++) begin
      reset  = ($urandom_range(0, 399) == 0);
      enable = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 39) == 0)  tgt_duty = DW'($urandom_range(0, 3000));
      if ($urandom_range(0, 149) == 0) tgt_dir = ~tgt_dir;
      if ($urandom_range(0, 99) == 0)  step = SW'($urandom_range(0, 255));
      if (m_st != 2 && $urandom_range(0, 9) == 0) ramp_div = VW'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0)  dead_cycles = VW'($urandom_range(0, 6));
      cyc($urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
